// File: rtl/b_dly_code_ctrl.sv
// Delay-code controller: slews the applied {coarse, fine} code toward a target, one LSB per STEP_CYC cycles.
// Define DLY_CTRL_THERM_EN to add the registered fine thermometer output o_sel_fine.
module b_dly_code_ctrl #(
    parameter int unsigned FINE_BITS   = 6,
    parameter int unsigned COARSE_BITS = 3,
    parameter int unsigned STEP_CYC    = 4,
    parameter logic [FINE_BITS+COARSE_BITS-1:0] RST_CODE = '0
) (
    input  logic                              i_clk,
    input  logic                              i_rstn,
    input  logic                              i_tgt_vld,
    output logic                              o_tgt_rdy,
    input  logic [FINE_BITS+COARSE_BITS-1:0]  i_tgt_code,
    input  logic                              i_freeze,
    output logic [FINE_BITS+COARSE_BITS-1:0]  o_dly_sel,
`ifdef DLY_CTRL_THERM_EN
    output logic [2**FINE_BITS-1:0]           o_sel_fine,
`endif
    output logic                              o_busy,
    output logic                              o_done
);

    localparam int unsigned W     = FINE_BITS + COARSE_BITS;
    localparam int unsigned CNT_W = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_CYC - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [W-1:0]     tgt, tgt_nxt;
    logic [W-1:0]     code_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

`ifdef DLY_CTRL_THERM_EN
    localparam int unsigned T = 1 << FINE_BITS;

    function automatic logic [T-1:0] therm(input logic [FINE_BITS-1:0] f);
        logic [T-1:0] t;
        t = '0;
        for (int unsigned k = 0; k < T; k++) begin
            t[k] = (k < 32'(f));
        end
        return t;
    endfunction
`endif

    assign o_tgt_rdy = (state == S_IDLE);

    always_comb begin
        state_nxt = state;
        tgt_nxt   = tgt;
        cnt_nxt   = cnt;
        code_nxt  = o_dly_sel;
        case (state)
            S_IDLE: begin
                if (i_tgt_vld) begin
                    tgt_nxt   = i_tgt_code;
                    cnt_nxt   = '0;
                    state_nxt = (i_tgt_code == o_dly_sel) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (!i_freeze) begin
                    if (cnt != CNT_MAX) begin
                        cnt_nxt = cnt + 1'b1;
                    end else begin
                        // Single W-bit add/sub lets fine carry/borrow flow into coarse.
                        cnt_nxt  = '0;
                        code_nxt = (tgt > o_dly_sel) ? o_dly_sel + 1'b1 : o_dly_sel - 1'b1;
                        if (code_nxt == tgt) begin
                            state_nxt = S_DONE;
                        end
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state      <= S_IDLE;
            tgt        <= '0;
            cnt        <= '0;
            o_dly_sel  <= RST_CODE;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
`ifdef DLY_CTRL_THERM_EN
            o_sel_fine <= therm(RST_CODE[FINE_BITS-1:0]);
`endif
        end else begin
            state      <= state_nxt;
            tgt        <= tgt_nxt;
            cnt        <= cnt_nxt;
            o_dly_sel  <= code_nxt;
            o_busy     <= (state_nxt == S_RUN);
            o_done     <= (state_nxt == S_DONE);
`ifdef DLY_CTRL_THERM_EN
            o_sel_fine <= therm(code_nxt[FINE_BITS-1:0]);
`endif
        end
    end

endmodule
